vga_raster_gen: RTL and testbench

- Raster timing source and output stage for the 1280x800 display path.
- Generates the pixel coordinate stream `curr_x`/`curr_y`/`active_area` that feeds the tetris renderer.
- Takes the renderer's RGB result back after a fixed render latency, blanks it outside the active area and registers it.
- Drives the VGA pins with hsync/vsync delayed to match the RGB output exactly.

---
 rtl/vga_raster_if.sv | 28 ++
 rtl/vga_raster_gen.sv | 143 ++++++++++++++
 tb/tb_vga_raster_gen.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/vga_raster_if.sv
// Signal bundle between the raster generator, the renderer it drives and the VGA pins.
// The master side is the raster generator; the slave side is the renderer/monitor.
interface vga_raster_if;
    logic [10:0] curr_x;
    logic [9:0]  curr_y;
    logic        active_area;
    logic        frame_start;
    logic        line_start;
    logic [15:0] frame_count;
    logic [11:0] rgb_in;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;

    modport master (
        output curr_x, curr_y, active_area, frame_start, line_start, frame_count,
        input  rgb_in,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs
    );

    modport slave (
        input  curr_x, curr_y, active_area, frame_start, line_start, frame_count,
        output rgb_in,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs
    );
endinterface

// File: rtl/vga_raster_gen.sv
// Raster timing source for the 1280x800 path: emits pixel coordinates to the renderer and
// re-times the returned colour together with hsync/vsync onto the VGA pins.
module vga_raster_gen #(
    parameter int H_ACTIVE   = 1280,
    parameter int H_FP       = 72,
    parameter int H_SYNC     = 128,
    parameter int H_BP       = 200,
    parameter int V_ACTIVE   = 800,
    parameter int V_FP       = 3,
    parameter int V_SYNC     = 6,
    parameter int V_BP       = 22,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b1,
    parameter int RENDER_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    vga_raster_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] X_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] X_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  Y_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  Y_ACT_END = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_START  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Per-pixel tag {active, hs, vs}; IDLE is what the pins show with no pixel in flight.
    localparam logic [2:0] IDLE = {1'b0, ~HS_POL, ~VS_POL};

    logic        started_q, started_d;
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        active_q, active_d;
    logic        frame_start_q, frame_start_d;
    logic        line_start_q, line_start_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;

    logic        hs_raw;
    logic        vs_raw;
    logic [2:0]  pix_tag;
    logic [2:0]  dly_tag;

    // Until the first edge after release nothing has been presented, so the coordinate
    // stays parked at (0,0) and that edge presents pixel 0 instead of advancing.
    always_comb begin
        started_d = 1'b1;
        x_d       = '0;
        y_d       = '0;
        if (started_q) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 11'd1;
                y_d = y_q;
            end
        end
        active_d      = (x_d < X_ACT_END) && (y_d < Y_ACT_END);
        line_start_d  = (x_d == 11'd0);
        frame_start_d = line_start_d && (y_d == 10'd0);
        frame_count_d = frame_count_q + 16'(frame_start_d);
    end

    always_comb begin
        hs_raw  = ((x_q >= HS_START) && (x_q < HS_END)) ? HS_POL : ~HS_POL;
        vs_raw  = ((y_q >= VS_START) && (y_q < VS_END)) ? VS_POL : ~VS_POL;
        pix_tag = started_q ? {active_q, hs_raw, vs_raw} : IDLE;
    end

    // Delay the tag of the presented pixel by the renderer latency so it meets its colour.
    generate
        if (RENDER_LAT == 0) begin : g_no_pipe
            assign dly_tag = pix_tag;
        end else begin : g_pipe
            logic [2:0] pipe_q [RENDER_LAT];
            logic [2:0] pipe_d [RENDER_LAT];
            for (genvar gi = 0; gi < RENDER_LAT; gi++) begin : g_stage
                if (gi == 0) begin : g_first
                    assign pipe_d[gi] = pix_tag;
                end else begin : g_rest
                    assign pipe_d[gi] = pipe_q[gi-1];
                end
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) pipe_q[gi] <= IDLE;
                    else        pipe_q[gi] <= pipe_d[gi];
                end
            end
            assign dly_tag = pipe_q[RENDER_LAT-1];
        end
    endgenerate

    always_comb begin
        rgb_d = dly_tag[2] ? bus.rgb_in : 12'h000;
        hs_d  = dly_tag[1];
        vs_d  = dly_tag[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q     <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
            frame_count_q <= '0;
            rgb_q         <= '0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
        end else begin
            started_q     <= started_d;
            x_q           <= x_d;
            y_q           <= y_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
            frame_count_q <= frame_count_d;
            rgb_q         <= rgb_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
        end
    end

    assign bus.curr_x      = x_q;
    assign bus.curr_y      = y_q;
    assign bus.active_area = active_q;
    assign bus.frame_start = frame_start_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_count = frame_count_q;
    assign bus.vga_r       = rgb_q[11:8];
    assign bus.vga_g       = rgb_q[7:4];
    assign bus.vga_b       = rgb_q[3:0];
    assign bus.vga_hs      = hs_q;
    assign bus.vga_vs      = vs_q;
endmodule

// File: tb/tb_vga_raster_gen.sv
// Bench for vga_raster_gen on a shrunken raster (35x13) so whole frames fit in a short run;
// expectations come from the pixel index since release using plain div/mod arithmetic.
module tb_vga_raster_gen;
    localparam int HA = 20, HF = 4, HSY = 6, HB = 5;
    localparam int VA = 6,  VF = 2, VSY = 3, VB = 2;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int FT = HT * VT;
    localparam bit HS_POL = 1'b0;
    localparam bit VS_POL = 1'b1;
    localparam int L = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    vga_raster_if bus ();

    vga_raster_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .RENDER_LAT(L)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int k = 0;
    int mode = 0;
    int cap_mode = 0;
    logic [11:0] cap_val = '0;
    logic [10:0] x_hold = '0;
    int hs_run = 0;
    int vs_run = 0;
    int last_fs = 0;

    function automatic logic [39:0] raster_exp(int kk);
        int p, x, y, fc;
        logic act, fs, ls;
        if (kk == 0) return '0;
        p   = kk - 1;
        x   = p % HT;
        y   = (p / HT) % VT;
        fc  = (p / FT + 1) % 65536;
        act = (x < HA) && (y < VA);
        fs  = (x == 0) && (y == 0);
        ls  = (x == 0);
        return {11'(x), 10'(y), act, fs, ls, 16'(fc)};
    endfunction

    function automatic logic [13:0] pins_exp(int kk, int md, logic [11:0] val);
        int q, x, y;
        logic act, hs, vs;
        logic [11:0] col;
        q = kk - L - 2;
        if (kk == 0 || q < 0) return {12'h000, ~HS_POL, ~VS_POL};
        x   = q % HT;
        y   = (q / HT) % VT;
        act = (x < HA) && (y < VA);
        hs  = (x >= HA + HF && x < HA + HF + HSY) ? HS_POL : ~HS_POL;
        vs  = (y >= VA + VF && y < VA + VF + VSY) ? VS_POL : ~VS_POL;
        col = (md == 2) ? 12'(x) : val;
        return {act ? col : 12'h000, hs, vs};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("raster", 64'({bus.curr_x, bus.curr_y, bus.active_area, bus.frame_start,
                           bus.line_start, bus.frame_count}), 64'(raster_exp(k)));
        chk("pins", 64'({bus.vga_r, bus.vga_g, bus.vga_b, bus.vga_hs, bus.vga_vs}),
            64'(pins_exp(k, cap_mode, cap_val)));
        if (!rst_n) begin
            hs_run = 0; vs_run = 0; last_fs = 0;
        end else begin
            if (bus.vga_hs == HS_POL) hs_run++;
            else if (hs_run > 0) begin chk("hs_width", 64'(hs_run), 64'(HSY)); hs_run = 0; end
            if (bus.vga_vs == VS_POL) vs_run++;
            else if (vs_run > 0) begin chk("vs_width", 64'(vs_run), 64'(VSY * HT)); vs_run = 0; end
            if (bus.frame_start) begin
                if (last_fs > 0) chk("frame_len", 64'(k - last_fs), 64'(FT));
                last_fs = k;
            end
        end
    endtask

    task automatic drive();
        logic [11:0] v;
        case (mode)
            1:       v = 12'hFFF;
            2:       v = 12'(x_hold);
            default: v = 12'($urandom);
        endcase
        x_hold    = bus.curr_x;
        cap_mode  = mode;
        cap_val   = v;
        bus.rgb_in = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rst_n) k++;
        check_all();
        drive();
    endtask

    initial begin
        bit hit;
        bus.rgb_in = '0;
        rst_n = 1'b0;
        repeat (5) step();
        rst_n = 1'b1;

        mode = 0; repeat (500) step();
        mode = 1; repeat (460) step();
        mode = 2; repeat (460) step();
        mode = 0; repeat (300) step();

        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            step();
            hit = (bus.curr_x == 11'd12) && (bus.curr_y == 10'd4);
        end
        chk("mid_reach", 64'(hit), 64'd1);

        #3;
        rst_n = 1'b0;
        #1;
        k = 0;
        check_all();
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("restart_fc", 64'(bus.frame_count), 64'd1);
        repeat (80) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
